// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - byte-serial RAM/IO port shared by instruction fetch and load/store
// Define MEM_ARB_RR_EN for round-robin arbitration; default build gives the data side fixed priority.
module mem_bus_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_flag,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic              own_ls;
    logic [2:0]        cnt, n_q;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q, rbuf, cap_word;
    logic [1:0]        cap_idx;
    logic              grant_if, grant_ls, gnt_wr, gnt_stall, run_stall, last_cap;
    logic [ADDR_W-1:0] gnt_addr, next_addr;
    logic [2:0]        gnt_n;
`ifdef MEM_ARB_RR_EN
    logic              rr_last;  // 0 = fetch side granted last, 1 = data side
`endif

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !clear_flag) begin
`ifdef MEM_ARB_RR_EN
            if (if_req && ls_req) begin
                grant_ls = !rr_last;
                grant_if = rr_last;
            end else begin
                grant_ls = ls_req;
                grant_if = if_req;
            end
`else
            grant_ls = ls_req;
            grant_if = if_req && !ls_req;
`endif
        end
    end

    always_comb begin
        gnt_addr  = grant_ls ? ls_addr : if_addr;
        gnt_wr    = grant_ls && ls_wr;
        gnt_n     = !grant_ls ? 3'd4 : (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
        gnt_stall = (gnt_addr[17:16] == IO_HI) && io_buffer_full;
        run_stall = (base[17:16] == IO_HI) && io_buffer_full;
        next_addr = base + {{(ADDR_W-3){1'b0}}, cnt};
        last_cap  = (cnt == n_q + 3'd1);
        // Byte arriving on mem_din was addressed two edges earlier.
        cap_idx   = cnt[1:0] - 2'd2;
        cap_word  = rbuf;
        cap_word[8*cap_idx +: 8] = mem_din;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_if || grant_ls) state_next = gnt_wr ? WRITE : READ;
            READ:    if (clear_flag) state_next = IDLE;
                     else if (last_cap) state_next = DONE;
            WRITE:   if (!run_stall && cnt == n_q) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else if (rdy_in) state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
            own_ls   <= 1'b0;
            base     <= '0;
            n_q      <= '0;
            cnt      <= '0;
            wdata_q  <= '0;
            rbuf     <= '0;
`ifdef MEM_ARB_RR_EN
            rr_last  <= 1'b0;
`endif
        end else if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (grant_if || grant_ls) begin
                        own_ls  <= grant_ls;
                        base    <= gnt_addr;
                        n_q     <= gnt_n;
                        wdata_q <= ls_wdata;
                        rbuf    <= '0;
                        mem_a   <= gnt_addr;
`ifdef MEM_ARB_RR_EN
                        rr_last <= grant_ls;
`endif
                        if (gnt_wr && !gnt_stall) begin
                            mem_dout <= ls_wdata[7:0];
                            mem_wr   <= 1'b1;
                        end
                        cnt <= (gnt_wr && gnt_stall) ? 3'd0 : 3'd1;
                    end
                end
                READ: begin
                    // A flush drops any read in flight, including uncommitted loads.
                    if (!clear_flag) begin
                        if (cnt < n_q) mem_a <= next_addr;
                        if (cnt >= 3'd2) rbuf <= cap_word;
                        if (last_cap) begin
                            if (own_ls) begin
                                ls_done  <= 1'b1;
                                ls_rdata <= cap_word;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= cap_word;
                            end
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                WRITE: begin
                    if (run_stall) begin
                        mem_wr <= 1'b0;
                    end else if (cnt < n_q) begin
                        mem_a    <= next_addr;
                        mem_dout <= wdata_q[8*cnt[1:0] +: 8];
                        mem_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end else begin
                        mem_wr  <= 1'b0;
                        ls_done <= 1'b1;
                    end
                end
                default: mem_wr <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter against a byte-RAM model
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    mem_bus_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM with one cycle read latency; it shares the global enable with the core.
    logic [7:0]  ram [0:262143];
    logic [31:0] wlog_a [0:2047];
    logic [7:0]  wlog_d [0:2047];
    int          wlog_n = 0;

    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) begin
                ram[mem_a[17:0]]     <= mem_dout;
                wlog_a[wlog_n[10:0]] <= mem_a;
                wlog_d[wlog_n[10:0]] <= mem_dout;
                wlog_n               <= wlog_n + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_side = 0;  // 0 = fetch side granted last, 1 = data side

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ak;
        w = '0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            w[8*k +: 8] = ram[ak[17:0]];
        end
        return w;
    endfunction

    function automatic int pick_winner();
        return (RR_EN && last_side == 1) ? 0 : 1;
    endfunction

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        last_side = 0;
    endtask

    task automatic check_log(input string tag, input int log0, input int n,
                             input logic [31:0] a, input logic [31:0] wd);
        int idx;
        check({tag, " wcount"}, 32'(wlog_n - log0), 32'(n));
        for (int k = 0; k < n && k < wlog_n - log0; k++) begin
            idx = log0 + k;
            check({tag, " waddr"}, wlog_a[idx[10:0]], a + 32'(k));
            check({tag, " wdata"}, 32'(wlog_d[idx[10:0]]), 32'(wd[8*k +: 8]));
        end
    endtask

    task automatic run_txn(input string tag, input bit do_if, input logic [31:0] ia,
                           input bit do_ls, input logic lw, input logic [1:0] lsz,
                           input logic [31:0] la, input logic [31:0] lwd, input bit noise);
        logic [31:0] exp_if, exp_ls;
        int n, log0, cyc, first, win;
        bit pend_if, pend_ls;
        n      = (lsz == 2'd0) ? 1 : (lsz == 2'd1) ? 2 : 4;
        exp_if = model_read(ia, 4);
        exp_ls = model_read(la, n);
        win    = pick_winner();
        log0   = wlog_n;
        if_addr = ia; ls_wr = lw; ls_size = lsz; ls_addr = la; ls_wdata = lwd;
        if_req  = do_if; ls_req = do_ls;
        pend_if = do_if; pend_ls = do_ls;
        first = -1; cyc = 0;
        while ((pend_if || pend_ls) && cyc < 400) begin
            tick();
            cyc++;
            if (pend_if && if_done) begin
                check({tag, " if_data"}, if_data, exp_if);
                if_req = 1'b0; pend_if = 1'b0;
                if (first < 0) first = 0;
            end
            if (pend_ls && ls_done) begin
                if (!lw) check({tag, " ls_rdata"}, ls_rdata, exp_ls);
                ls_req = 1'b0; pend_ls = 1'b0;
                if (first < 0) first = 1;
            end
            if (noise) begin
                rdy_in = ($urandom_range(0, 3) != 0);
                io_buffer_full = ($urandom_range(0, 2) == 0);
            end
        end
        rdy_in = 1'b1; io_buffer_full = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        check({tag, " timeout"}, 32'(pend_if || pend_ls), 32'd0);
        if (do_if && do_ls) begin
            check({tag, " winner"}, 32'(first), 32'(win));
            last_side = 1 - first;
        end else begin
            last_side = do_ls ? 1 : 0;
        end
        check_log(tag, log0, (do_ls && lw) ? n : 0, la, lwd);
        cyc = 0;
        while ((if_done || ls_done) && cyc < 10) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [31:0] ia, la, lwd, got_a;
        logic [1:0]  lsz;
        logic        lw;
        int          mode, w, seen, log0;

        for (int a = 0; a < 262144; a++) ram[a] = 8'h00;
        for (int a = 0; a < 'h40; a++) ram[a] = 8'($urandom);
        for (int a = 'h100; a < 'h200; a++) ram[a] = 8'($urandom);
        for (int a = 'h3FFFC; a < 'h40000; a++) ram[a] = 8'($urandom);

        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0;
        ls_addr = '0; ls_wdata = '0;
        repeat (3) tick();
        check("reset mem_a", mem_a, 32'd0);
        check("reset mem_dout", 32'(mem_dout), 32'd0);
        check("reset mem_wr", 32'(mem_wr), 32'd0);
        check("reset dones", {30'd0, if_done, ls_done}, 32'd0);
        check("reset if_data", if_data, 32'd0);
        check("reset ls_rdata", ls_rdata, 32'd0);
        rst_in = 1'b0;
        last_side = 0;

        // Instruction word read, cycle by cycle
        ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'h00; ram['h103] = 8'h00;
        if_addr = 32'h100; if_req = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e <= 3) check($sformatf("ifrd mem_a E%0d", e), mem_a, 32'h100 + 32'(e));
            check($sformatf("ifrd mem_wr E%0d", e), 32'(mem_wr), 32'd0);
            check($sformatf("ifrd if_done E%0d", e), 32'(if_done), 32'(e == 5));
        end
        check("ifrd if_data", if_data, 32'h00000513);
        if_req = 1'b0;
        tick();

        // IO byte store held off by UART back-pressure
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("io stall mem_wr c%0d", c), 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        w = 0;
        do begin
            tick();
            w++;
        end while (!mem_wr && w < 4);
        check("io issue mem_wr", 32'(mem_wr), 32'd1);
        check("io issue mem_dout", 32'(mem_dout), 32'h41);
        check("io issue mem_a", mem_a, 32'h30000);
        tick();
        check("io ls_done", 32'(ls_done), 32'd1);
        check("io mem_wr after", 32'(mem_wr), 32'd0);
        ls_req = 1'b0;
        tick();

        // Simultaneous requests after reset
        do_reset();
        ram['h2000] = 8'h34; ram['h2001] = 8'h12;
        run_txn("arb1", 1, 32'h108, 1, 1'b0, 2'd1, 32'h2000, 32'd0, 0);
        check("arb1 half", ls_rdata, 32'h00001234);
        run_txn("arb2", 1, 32'h10C, 1, 1'b0, 2'd1, 32'h2000, 32'd0, 0);
        run_txn("arb3", 0, 32'h0, 1, 1'b0, 2'd2, 32'h10, 32'd0, 0);
        run_txn("arb4", 1, 32'h110, 1, 1'b0, 2'd1, 32'h2000, 32'd0, 0);

        // Flush during an instruction read
        if_addr = 32'h114; if_req = 1'b1;
        tick();
        last_side = 0;
        tick();
        clear_flag = 1'b1; if_req = 1'b0;
        tick();
        clear_flag = 1'b0;
        seen = 32'(if_done);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_done) seen++;
        end
        check("flush no if_done", 32'(seen), 32'd0);
        run_txn("flush ls", 0, 32'h0, 1, 1'b0, 2'd2, 32'h20, 32'd0, 0);

        // Flush during a committed store is ignored
        log0 = wlog_n;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h1000; ls_wdata = 32'hDEADBEEF;
        tick();
        tick();
        clear_flag = 1'b1;
        tick();
        clear_flag = 1'b0;
        w = 0;
        while (!ls_done && w < 10) begin
            tick();
            w++;
        end
        check("flush st ls_done", 32'(ls_done), 32'd1);
        ls_req = 1'b0;
        check_log("flush st", log0, 4, 32'h1000, 32'hDEADBEEF);
        last_side = 1;
        tick();

        // Global enable low mid read
        ram['h120] = 8'hAA; ram['h121] = 8'hBB; ram['h122] = 8'hCC; ram['h123] = 8'hDD;
        if_addr = 32'h120; if_req = 1'b1;
        tick();
        tick();
        got_a = mem_a;
        check("rdy mem_a before", got_a, 32'h121);
        rdy_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("rdy frozen mem_a c%0d", c), mem_a, 32'h121);
            check($sformatf("rdy frozen if_done c%0d", c), 32'(if_done), 32'd0);
        end
        rdy_in = 1'b1;
        w = 0;
        while (!if_done && w < 10) begin
            tick();
            w++;
        end
        check("rdy if_done", 32'(if_done), 32'd1);
        check("rdy if_data", if_data, 32'hDDCCBBAA);
        if_req = 1'b0;
        last_side = 0;
        tick();

        // Reset in the middle of a read
        if_addr = 32'h124; if_req = 1'b1;
        repeat (3) tick();
        rst_in = 1'b1; if_req = 1'b0;
        tick();
        check("midrst mem_a", mem_a, 32'd0);
        check("midrst mem_dout/wr", {23'd0, mem_dout, mem_wr}, 32'd0);
        check("midrst dones", {30'd0, if_done, ls_done}, 32'd0);
        check("midrst if_data", if_data, 32'd0);
        check("midrst ls_rdata", ls_rdata, 32'd0);
        rst_in = 1'b0;
        last_side = 0;

        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 2);
            ia   = 32'h100 + $urandom_range(0, 250);
            case ($urandom_range(0, 9))
                7, 8:    la = 32'h30000 + $urandom_range(0, 3);
                9:       la = 32'hFFFFFFFC + $urandom_range(0, 3);
                default: la = 32'($urandom_range(0, 60));
            endcase
            lw  = 1'($urandom_range(0, 1));
            lsz = 2'($urandom_range(0, 3));
            lwd = $urandom;
            run_txn($sformatf("rnd%0d", i), mode != 1, ia, mode != 0, lw, lsz, la, lwd, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
